// File: rtl/param_sp_ram.sv
// Single-port synchronous RAM with byte strobes, 1/2-cycle read latency,
// read-valid flag, hardware clear sweep and illegal-request error pulse.

module param_sp_ram_lane #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        q
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Read register only moves on an in-range read, so it holds between reads.
  always_ff @(posedge clk)
    if (!reset)  q <= '0;
    else if (re) q <= mem[raddr];
endmodule

module param_sp_ram #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 5,
  parameter int                DEPTH          = 32,
  parameter int                RD_LAT         = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VAL       = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic                  clr_start,
  output logic                  ready,
  output logic                  busy,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  err
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state;
  logic                   boot;
  logic [ADDR_W-1:0]      cnt;
  logic                   clearing, in_range, wr_acc, rd_acc, ill;
  logic [ADDR_W-1:0]      waddr;
  logic [NB-1:0]          lane_we;
  logic [NB-1:0][7:0]     lane_wd, lane_q;
  logic [RD_LAT:1]        vld_pipe;
  logic                   oor_q;
  logic [DATA_W-1:0]      s1_data;

  assign clearing = (state == CLEAR);
  assign busy     = clearing;
  assign ready    = (state == IDLE) && reset;
  assign in_range = {1'b0, address} < (ADDR_W+1)'(DEPTH);
  assign wr_acc   = ready && write_enb && !read_enb && in_range;
  assign rd_acc   = ready && read_enb && !write_enb;
  assign ill      = ready && ((write_enb && read_enb) ||
                              ((write_enb || read_enb) && !in_range));
  assign waddr    = clearing ? cnt : address;

  // boot marks the first cycle after reset release for the auto-clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      boot  <= 1'b1;
      cnt   <= '0;
    end else begin
      boot <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if ((boot && CLEAR_ON_RESET != 0) || clr_start) state <= CLEAR;
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign lane_we[i] = clearing || (wr_acc && wstrb[i]);
    assign lane_wd[i] = clearing ? INIT_VAL[8*i +: 8] : data_in[8*i +: 8];
    param_sp_ram_lane #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (lane_we[i]),
      .waddr (waddr),
      .wdata (lane_wd[i]),
      .re    (rd_acc && in_range),
      .raddr (address),
      .q     (lane_q[i])
    );
  end

  // Out-of-range reads still produce a valid beat, forced to zero.
  assign s1_data = oor_q ? '0 : lane_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      oor_q    <= 1'b0;
      err      <= 1'b0;
    end else begin
      vld_pipe <= RD_LAT'({vld_pipe, rd_acc});
      if (rd_acc) oor_q <= !in_range;
      err <= ill;
    end
  end

  assign rd_valid = vld_pipe[RD_LAT];

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] out_q;
    always_ff @(posedge clk)
      if (!reset)           out_q <= '0;
      else if (vld_pipe[1]) out_q <= s1_data;
    assign data_out = out_q;
  end else begin : g_lat1
    assign data_out = s1_data;
  end
endmodule

// File: tb/tb_param_sp_ram.sv
// Scoreboard bench: stimulus pushes expected reads/errs, a negedge monitor pops.

module tb_param_sp_ram;
  localparam int DW = 32, AW = 5, DEPTH = 20, RL = 2;
  localparam logic [31:0] INIT = 32'hDEAD_BEEF;

  logic          clk = 1'b0, reset = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic [3:0]    wstrb = '0;
  logic          write_enb = 1'b0, read_enb = 1'b0, clr_start = 1'b0;
  logic          ready, busy, rd_valid, err;
  logic [DW-1:0] data_out;

  param_sp_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RL),
                 .CLEAR_ON_RESET(1), .INIT_VAL(INIT)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .wstrb(wstrb), .write_enb(write_enb), .read_enb(read_enb),
    .clr_start(clr_start), .ready(ready), .busy(busy),
    .data_out(data_out), .rd_valid(rd_valid), .err(err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  typedef struct { logic [31:0] data; int cyc; } rd_t;
  rd_t         rdq[$];
  int          errq[$];
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    bit  e_exp;
    rd_t r;
    if (reset) begin
      e_exp = 1'b0;
      if (errq.size() > 0 && errq[0] == cyc) begin
        e_exp = 1'b1;
        void'(errq.pop_front());
      end
      if (err || e_exp) begin
        n_cmp++;
        if (err !== e_exp) begin
          n_bad++;
          $display("FAIL err_pulse: got=%b expected=%b (cyc %0d)", err, e_exp, cyc);
        end
      end
      if (rd_valid) begin
        n_cmp++;
        if (rdq.size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected: got data=%h, expected no rd_valid (cyc %0d)", data_out, cyc);
        end else begin
          r = rdq.pop_front();
          if (data_out !== r.data || cyc != r.cyc) begin
            n_bad++;
            $display("FAIL rd_data: got=%h @%0d expected=%h @%0d", data_out, cyc, r.data, r.cyc);
          end
        end
      end else if (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
        r = rdq.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL rd_missing: got no rd_valid @%0d expected=%h", cyc, r.data);
      end
    end
  end

  // One request cycle while idle; called and returns at a negedge.
  task automatic req(input bit we, input bit re, input bit clr, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    logic inr;
    write_enb = we; read_enb = re; clr_start = clr;
    address = a; data_in = d; wstrb = s;
    inr = (a < DEPTH);
    if ((we && re) || ((we || re) && !inr)) errq.push_back(cyc + 1);
    if (re && !we) rdq.push_back('{data: (inr ? ref_mem[a] : 32'h0), cyc: cyc + RL});
    if (we && !re && inr)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    @(negedge clk);
    write_enb = 0; read_enb = 0; clr_start = 0;
  endtask

  // Counts busy cycles of one sweep; optionally pokes requests mid-sweep.
  task automatic sweep_check(input string name, input bit poke);
    int nb;
    nb = 0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      if (busy) nb++;
      else if (nb > 0) break;
      if (poke && nb == 5) begin
        write_enb = 1; address = 3; data_in = 32'h1234_5678; wstrb = 4'hF; clr_start = 1;
        chk("ready_while_busy", {31'b0, ready}, 32'd0);
      end else if (poke && nb == 6) begin
        write_enb = 0; read_enb = 1; clr_start = 0;
      end else begin
        write_enb = 0; read_enb = 0; clr_start = 0;
      end
      @(negedge clk);
    end
    chk(name, nb, DEPTH);
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = INIT;
  endtask

  task automatic reset_pulse(input string name);
    reset = 0;
    rdq.delete(); errq.delete();
    @(negedge clk);
    chk({name, "_data_out"}, data_out, 32'h0);
    chk({name, "_flags"}, {27'b0, rd_valid, err, busy, ready, 1'b0}, 32'h0);
    reset = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_flags", {27'b0, rd_valid, err, busy, ready, 1'b0}, 32'h0);
    reset = 1;
    sweep_check("boot_sweep_len", 1'b1);

    for (int a = 0; a < DEPTH; a++) req(0, 1, 0, AW'(a), 0, 0);

    req(1, 0, 0, 5, 32'hAABB_CCDD, 4'hF);
    req(1, 0, 0, 5, 32'h1122_3344, 4'b0101);
    req(0, 1, 0, 5, 0, 0);

    for (int a = 1; a <= 3; a++) req(1, 0, 0, AW'(a), 32'h0101_0101 * a, 4'hF);
    for (int a = 1; a <= 3; a++) req(0, 1, 0, AW'(a), 0, 0);

    req(1, 0, 0, 9, 32'hCAFE_F00D, 4'hF);
    req(0, 1, 0, 9, 0, 0);
    req(1, 0, 0, 9, 32'hFFFF_FFFF, 4'h0);
    req(0, 1, 0, 9, 0, 0);

    req(1, 0, 0, 7, 32'h7777_7777, 4'hF);
    req(1, 1, 0, 7, 32'h0, 4'hF);
    req(0, 1, 0, 7, 0, 0);

    req(1, 0, 0, 19, 32'h1919_1919, 4'hF);
    req(0, 1, 0, 19, 0, 0);
    req(0, 1, 0, 25, 0, 0);
    req(1, 0, 0, 25, 32'h5555_5555, 4'hF);
    req(0, 1, 0, 19, 0, 0);

    req(0, 1, 1, 5, 0, 0);
    sweep_check("clr_read_sweep_len", 1'b0);
    req(1, 0, 1, 4, 32'h4444_4444, 4'hF);
    sweep_check("clr_write_sweep_len", 1'b0);
    req(0, 1, 0, 4, 0, 0);
    req(0, 1, 0, 5, 0, 0);

    req(1, 0, 0, 0, 32'h0000_AAAA, 4'hF);
    req(0, 0, 1, 0, 0, 0);
    repeat (9) @(negedge clk);
    chk("busy_mid_sweep", {31'b0, busy}, 32'd1);
    reset_pulse("mid_sweep_reset");
    sweep_check("restart_sweep_len", 1'b0);
    req(0, 1, 0, 0, 0, 0);
    req(0, 1, 0, 19, 0, 0);

    req(1, 0, 0, 2, 32'h2222_2222, 4'hF);
    req(0, 1, 0, 2, 0, 0);
    reset_pulse("inflight_reset");
    sweep_check("post_reset_sweep_len", 1'b0);
    req(0, 1, 0, 2, 0, 0);

    repeat (5) @(negedge clk);
    chk("rd_queue_drained", rdq.size(), 0);
    chk("err_queue_drained", errq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/param_sp_ram.md
Name: param_sp_ram

Overview:
Parametrised single-port synchronous RAM with separate read and write enables. It adds per-byte write strobes, a configurable read latency and a valid flag on read data. A hardware clear engine sweeps the array to a known value after reset or on request, and illegal requests raise an error pulse. It is a drop-in storage block for datapath buffers and register-file style scratch memories.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 8.
ADDR_W, 5, address width.
DEPTH, 32, number of words; 1 <= DEPTH <= 2**ADDR_W.
RD_LAT, 1, read latency in cycles; legal values 1 or 2.
CLEAR_ON_RESET, 1, when 1 the clear sweep starts automatically when reset is released.
INIT_VAL, 0, DATA_W-bit value written by the clear sweep.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
address  in  ADDR_W  word address
data_in  in  DATA_W  write data
wstrb  in  DATA_W/8  byte write enables; bit i covers data_in[8i+7:8i]
write_enb  in  1  write request
read_enb  in  1  read request
clr_start  in  1  one-cycle request to start a clear sweep
ready  out  1  1 = a request presented this cycle is accepted
busy  out  1  clear sweep in progress
data_out  out  DATA_W  read data, valid when rd_valid=1
rd_valid  out  1  data_out holds the result of an accepted read
err  out  1  one-cycle pulse flagging an illegal request

Behaviour:
- Reset (reset=0 sampled at a clk edge):
  - data_out=0, rd_valid=0, err=0.
  - Read pipeline flushed; any in-flight read is dropped.
  - FSM goes to IDLE with ready=0 and busy=0.
  - Array contents are not reset.
- Clear FSM states IDLE, CLEAR:
  - First cycle after reset release: go to CLEAR if CLEAR_ON_RESET=1, else stay in IDLE.
  - In IDLE, clr_start=1 moves the FSM to CLEAR; the clear counter is loaded with 0.
  - In CLEAR, one word per cycle is written with INIT_VAL at the counter address, all bytes.
  - After address DEPTH-1 is written, return to IDLE. The sweep takes exactly DEPTH cycles.
  - busy=1 and ready=0 throughout CLEAR. clr_start is ignored while busy.
  - Reset asserted mid-sweep aborts the sweep. The sweep restarts from address 0 after release only when CLEAR_ON_RESET=1.
- ready = (state==IDLE) and reset deasserted. Requests presented while ready=0 are ignored, not queued, and raise no err.
- Accepted write (write_enb=1, read_enb=0, ready=1):
  - Only bytes with wstrb[i]=1 are updated; the others keep their contents.
  - wstrb=0 is a legal no-op.
- Accepted read (read_enb=1, write_enb=0, ready=1):
  - rd_valid pulses for one cycle, RD_LAT cycles after the request edge, with data_out=mem[address].
  - Back-to-back reads on consecutive cycles give back-to-back rd_valid pulses.
  - With RD_LAT=2 the extra stage is a registered output stage.
- data_out holds its last value when rd_valid=0; it never goes to Z or X after reset.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Illegal requests, signalled by err=1 on the cycle after the request:
  - write_enb=1 and read_enb=1 together: no memory change, no rd_valid.
  - address >= DEPTH on a read: rd_valid still pulses at the normal latency with data_out=0.
  - address >= DEPTH on a write: write dropped.
- clr_start=1 in IDLE together with a request: the request is accepted this cycle and the sweep starts the next cycle. The write lands before the sweep, so the sweep overwrites it.
- A read accepted just before CLEAR is entered completes normally. It returns pre-clear data, because the read was accepted before the sweep.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=32: release reset -> busy=1 for exactly 32 cycles; then read addr 0..31 -> each data_out=INIT_VAL with rd_valid.
- DATA_W=32: write 0xAABBCCDD with wstrb=4'hF to addr 5, then write 0x11223344 with wstrb=4'b0101 -> read addr 5 returns 0xAA22CC44.
- RD_LAT=2: reads of addr 1,2,3 on consecutive cycles -> rd_valid high on cycles +2,+3,+4 with matching data; write followed next cycle by read of the same address returns the new data.
- write_enb=read_enb=1 at addr 7 -> err pulse, memory unchanged, no rd_valid. DEPTH=20: read addr 25 -> err pulse, rd_valid with data_out=0.
- clr_start during an active sweep is ignored, and the sweep still takes DEPTH cycles. Reset asserted at sweep cycle 10 -> rd_valid=0, data_out=0, sweep restarts from 0 after release.
- Requests presented while busy=1 -> ready=0, no memory change, no err, no rd_valid.
